// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of single-ported data_memory.
// Optional feature macro ALIGN_CHECK_EN: block misaligned word accesses and report mN_err.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic              m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic              m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_size,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic              wr;
      logic              size;
      logic              mis;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   state_t            r_state, w_state_nxt;
   cmd_t              r_cmd, w_sel_cmd;
   logic              r_own, r_prio;
   logic              w_sel, w_load, w_resp;
   logic [1:0]        r_gnt, r_rvalid, r_err;
   logic [1:0]        w_gnt_nxt, w_rvalid_nxt, w_err_nxt;
   logic              r_mem_rd, r_mem_wr, w_mem_rd_nxt, w_mem_wr_nxt;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;
   logic [DATA_W-1:0] w_rdata_cap, w_rdata0_nxt, w_rdata1_nxt;

   // Next-state, arbitration and next values of every registered output
   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_sel        = 1'b0;
      w_sel_cmd    = '0;
      w_gnt_nxt    = 2'b00;
      w_rvalid_nxt = 2'b00;
      w_err_nxt    = 2'b00;
      w_mem_rd_nxt = 1'b0;
      w_mem_wr_nxt = 1'b0;
      w_rdata_cap  = '0;
      w_rdata0_nxt = '0;
      w_rdata1_nxt = '0;
      w_resp       = 1'b0;

      if (m0_req && m1_req) begin
         w_sel = r_prio;
      end else begin
         w_sel = m1_req;
      end

      w_sel_cmd.wr    = w_sel ? m1_wr    : m0_wr;
      w_sel_cmd.size  = w_sel ? m1_size  : m0_size;
      w_sel_cmd.addr  = w_sel ? m1_addr  : m0_addr;
      w_sel_cmd.wdata = w_sel ? m1_wdata : m0_wdata;
`ifdef ALIGN_CHECK_EN
      w_sel_cmd.mis   = w_sel_cmd.size & (|w_sel_cmd.addr[1:0]);
`else
      w_sel_cmd.mis   = 1'b0;
`endif

      case (r_state)
         S_IDLE, S_RESP: begin
            if (m0_req || m1_req) begin
               w_load      = 1'b1;
               w_state_nxt = S_ACCESS;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACCESS: w_state_nxt = S_RESP;
         default:  w_state_nxt = S_IDLE;
      endcase

      w_resp = (r_state == S_ACCESS);

      if (w_load) begin
         w_gnt_nxt    = w_sel ? 2'b10 : 2'b01;
         w_mem_rd_nxt = ~w_sel_cmd.wr & ~w_sel_cmd.mis;
         w_mem_wr_nxt =  w_sel_cmd.wr & ~w_sel_cmd.mis;
      end

      // Response data is captured at the edge that ends the access cycle
      if (w_resp) begin
         w_rvalid_nxt = r_own ? 2'b10 : 2'b01;
         w_err_nxt    = w_rvalid_nxt & {2{r_cmd.mis}};
         if (!r_cmd.wr && !r_cmd.mis) begin
            w_rdata_cap = mem_read_data;
         end
         if (r_own) begin
            w_rdata1_nxt = w_rdata_cap;
         end else begin
            w_rdata0_nxt = w_rdata_cap;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cmd    <= '0;
         r_own    <= 1'b0;
         r_prio   <= 1'b0;
         r_gnt    <= 2'b00;
         r_rvalid <= 2'b00;
         r_err    <= 2'b00;
         r_mem_rd <= 1'b0;
         r_mem_wr <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_rvalid <= w_rvalid_nxt;
         r_err    <= w_err_nxt;
         r_mem_rd <= w_mem_rd_nxt;
         r_mem_wr <= w_mem_wr_nxt;
         r_rdata0 <= w_rdata0_nxt;
         r_rdata1 <= w_rdata1_nxt;
         if (w_load) begin
            r_cmd  <= w_sel_cmd;
            r_own  <= w_sel;
            r_prio <= ~w_sel;
         end
      end
   end

   assign m0_gnt         = r_gnt[0];
   assign m1_gnt         = r_gnt[1];
   assign m0_rvalid      = r_rvalid[0];
   assign m1_rvalid      = r_rvalid[1];
   assign m0_err         = r_err[0];
   assign m1_err         = r_err[1];
   assign m0_rdata       = r_rdata0;
   assign m1_rdata       = r_rdata1;
   assign mem_address    = r_cmd.addr;
   assign mem_size       = r_cmd.size;
   assign mem_write_data = r_cmd.wdata;
   assign mem_rd         = r_mem_rd;
   assign mem_wr         = r_mem_wr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-array reference model, random and directed traffic.
// Build with ALIGN_CHECK_EN defined to exercise the misalignment error path.
module tb_dmem_arbiter;

   typedef struct packed {
      logic        wr;
      logic        size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } tcmd_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } texp_t;

   typedef struct {
      int m;
      int c;
   } tgnt_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m0_req, m0_wr, m0_size, m1_req, m1_wr, m1_size;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_size, mem_rd, mem_wr;

   logic [7:0]  env_mem [0:1023] = '{default: 8'h00};
   logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};

   tcmd_t cmdq [2][$];
   texp_t sbq  [2][$];
   tgnt_t gnt_log [$];
   tcmd_t cur [2];
   logic  active [2];
   logic  rst_at [2];
   int    waitc [2];
   int    gap [2];
   logic  rand_gap = 1'b0;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    n_gnt0 = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_address(mem_address), .mem_size(mem_size), .mem_write_data(mem_write_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int ix(input logic [31:0] a);
      return int'(a[9:0]);
   endfunction

   // data_memory stand-in: combinational read, write committed at the clock edge
   always_comb begin
      mem_read_data = '0;
      if (mem_size) begin
         for (int k = 0; k < 4; k++) mem_read_data[8*k +: 8] = env_mem[ix(mem_address + 32'(k))];
      end else begin
         mem_read_data[7:0] = env_mem[ix(mem_address)];
      end
   end

   always @(posedge clk) begin
      if (mem_wr) begin
         if (mem_size) begin
            for (int k = 0; k < 4; k++) env_mem[ix(mem_address + 32'(k))] <= mem_write_data[8*k +: 8];
         end else begin
            env_mem[ix(mem_address)] <= mem_write_data[7:0];
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired or unexpected event at t=%0t", nm, $time);
   endtask

   function automatic tcmd_t mk(input logic wr, input logic size, input logic [31:0] addr,
                                input logic [31:0] wdata);
      tcmd_t c;
      c.wr = wr; c.size = size; c.addr = addr; c.wdata = wdata;
      return c;
   endfunction

   function automatic logic mis_of(input tcmd_t c);
`ifdef ALIGN_CHECK_EN
      return c.size && (c.addr[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Reference: a byte-addressed memory applied in each master's issue order
   task automatic ref_access(input tcmd_t c, output texp_t e);
      e = '0;
      e.err = mis_of(c);
      if (!e.err) begin
         if (c.wr) begin
            for (int k = 0; k < (c.size ? 4 : 1); k++) ref_mem[ix(c.addr + 32'(k))] = c.wdata[8*k +: 8];
         end else begin
            for (int k = 0; k < (c.size ? 4 : 1); k++) e.rdata[8*k +: 8] = ref_mem[ix(c.addr + 32'(k))];
         end
      end
   endtask

   task automatic set_bus(input int m, input logic rq, input tcmd_t c);
      if (m == 0) begin
         m0_req = rq; m0_wr = c.wr; m0_size = c.size; m0_addr = c.addr; m0_wdata = c.wdata;
      end else begin
         m1_req = rq; m1_wr = c.wr; m1_size = c.size; m1_addr = c.addr; m1_wdata = c.wdata;
      end
   endtask

   function automatic tcmd_t rand_cmd(input int m);
      return mk(1'($urandom), 1'($urandom), 32'(m * 256) + 32'($urandom_range(0, 60)), $urandom);
   endfunction

   // Master drivers: hold req until gnt, then reissue or drop in the response cycle
   initial begin : drv
      logic [1:0] gs;
      logic       rs;
      tcmd_t      c;
      texp_t      e;
      for (int m = 0; m < 2; m++) begin
         active[m] = 1'b0; rst_at[m] = 1'b0; waitc[m] = 0; gap[m] = 0; cur[m] = '0;
         set_bus(m, 1'b0, '0);
      end
      forever begin
         @(negedge clk);
         gs = {m1_gnt, m0_gnt};
         rs = rst_n;
         @(posedge clk);
         #1;
         for (int m = 0; m < 2; m++) begin
            if (active[m]) begin
               if (gs[m]) begin
                  active[m] = 1'b0;
                  gap[m] = rand_gap ? $urandom_range(0, 3) : 0;
               end else if (rst_at[m] && !rs) begin
                  active[m] = 1'b0;
                  void'(sbq[m].pop_back());
                  gap[m] = 0;
               end else begin
                  waitc[m]++;
                  if (waitc[m] > 100) begin
                     fail("gnt_timeout");
                     active[m] = 1'b0;
                     void'(sbq[m].pop_back());
                  end
               end
            end
            if (!active[m]) begin
               if (gap[m] > 0) begin
                  gap[m]--;
                  set_bus(m, 1'b0, cur[m]);
               end else if (cmdq[m].size() > 0) begin
                  c = cmdq[m].pop_front();
                  cur[m] = c;
                  ref_access(c, e);
                  sbq[m].push_back(e);
                  active[m] = 1'b1;
                  waitc[m] = 0;
                  rst_at[m] = rs;
                  set_bus(m, 1'b1, c);
               end else begin
                  set_bus(m, 1'b0, cur[m]);
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on rvalid, checks bus contents and fairness on gnt
   initial begin : mon
      logic [1:0] preq, pend, gv, rv;
      int         prio_m;
      texp_t      e;
      logic       errx;
      tgnt_t      g;
      preq = 2'b00; pend = 2'b00; prio_m = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prio_m = 0;
            pend = 2'b00;
            preq = {m1_req, m0_req};
            continue;
         end
         if (mem_rd || mem_wr) chk("strobe_excl", 64'(mem_rd & mem_wr), 64'(0));
         gv = {m1_gnt, m0_gnt};
         rv = {m1_rvalid, m0_rvalid};
         for (int m = 0; m < 2; m++) begin
            if (pend[m]) chk("rvalid_after_gnt", 64'(rv[m]), 64'(1));
            else if (rv[m]) fail("rvalid_without_gnt");
            if (rv[m]) begin
               if (sbq[m].size() == 0) begin
                  fail("rvalid_no_expectation");
               end else begin
                  e = sbq[m].pop_front();
                  chk(m == 0 ? "m0_rdata" : "m1_rdata", 64'(m == 0 ? m0_rdata : m1_rdata), 64'(e.rdata));
                  chk(m == 0 ? "m0_err" : "m1_err", 64'(m == 0 ? m0_err : m1_err), 64'(e.err));
               end
               if (m == 0) chk("nonowner_m1", {31'h0, m1_rvalid, m1_err, m1_rdata}, 64'(0));
               else        chk("nonowner_m0", {31'h0, m0_rvalid, m0_err, m0_rdata}, 64'(0));
            end
            if (gv[m]) begin
               chk("gnt_excl", 64'(gv[1-m]), 64'(0));
               errx = mis_of(cur[m]);
               chk("bus_addr", 64'(mem_address), 64'(cur[m].addr));
               chk("bus_wdata", 64'(mem_write_data), 64'(cur[m].wdata));
               chk("bus_ctl", 64'({mem_rd, mem_wr, mem_size}),
                   64'({~cur[m].wr & ~errx, cur[m].wr & ~errx, cur[m].size}));
               if (preq == 2'b11) chk("rr_order", 64'(m), 64'(prio_m));
               prio_m = 1 - m;
               g.m = m; g.c = cyc;
               gnt_log.push_back(g);
               if (m == 0) n_gnt0++;
            end
         end
         pend = gv;
         preq = {m1_req, m0_req};
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (cmdq[0].size() != 0 || cmdq[1].size() != 0 || sbq[0].size() != 0 ||
             sbq[1].size() != 0 || active[0] || active[1]) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            fail("idle_timeout");
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : main
      int   base, g0;
      logic seen;
      // Reset held with m0 requesting: everything quiet, no grant
      cmdq[0].push_back(mk(1'b1, 1'b0, 32'd0, 32'h115));
      repeat (3) begin
         @(negedge clk);
         chk("reset_ctl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_rd, mem_wr, mem_size}), 64'(0));
         chk("reset_data", 64'(m0_rdata | m1_rdata | mem_address | mem_write_data), 64'(0));
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("first_gnt", 64'(m0_gnt), 64'(1));
      @(posedge clk); #1;
      chk("write_resp", {31'h0, m0_rvalid, m0_rdata}, {31'h0, 1'b1, 32'h0});
      wait_idle();

      // Byte read-back: gnt one cycle, rvalid two cycles after the sampling edge
      @(negedge clk);
      cmdq[0].push_back(mk(1'b0, 1'b0, 32'd0, 32'h0));
      @(posedge clk);
      @(posedge clk); #1;
      chk("read_gnt_lat", 64'(m0_gnt), 64'(1));
      @(posedge clk); #1;
      chk("read_rvalid_lat", 64'(m0_rvalid), 64'(1));
      chk("read_rdata", 64'(m0_rdata), 64'h15);
      wait_idle();

      // m1 alone: word write/read, m0 stays idle
      g0 = n_gnt0;
      @(negedge clk);
      cmdq[1].push_back(mk(1'b1, 1'b1, 32'd276, 32'hDEADBEEF));
      cmdq[1].push_back(mk(1'b0, 1'b1, 32'd276, 32'h0));
      wait_idle();
      chk("m1_only_no_m0_gnt", 64'(n_gnt0), 64'(g0));

      // Contention: six accesses alternate, one grant every two cycles
      base = gnt_log.size();
      @(negedge clk);
      cmdq[0].push_back(mk(1'b1, 1'b1, 32'd8, 32'hA5A5_1234));
      cmdq[0].push_back(mk(1'b0, 1'b1, 32'd8, 32'h0));
      cmdq[0].push_back(mk(1'b0, 1'b0, 32'd9, 32'h0));
      cmdq[1].push_back(mk(1'b1, 1'b0, 32'd300, 32'h77));
      cmdq[1].push_back(mk(1'b0, 1'b0, 32'd300, 32'h0));
      cmdq[1].push_back(mk(1'b0, 1'b1, 32'd276, 32'h0));
      wait_idle();
      chk("cont_count", 64'(gnt_log.size() - base), 64'(6));
      if (gnt_log.size() >= base + 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("cont_order", 64'(gnt_log[base+i].m), 64'(i % 2));
            if (i > 0) chk("cont_spacing", 64'(gnt_log[base+i].c - gnt_log[base+i-1].c), 64'(2));
         end
      end

      // Misaligned word read and byte read at the same address
      @(negedge clk);
      cmdq[0].push_back(mk(1'b0, 1'b1, 32'd277, 32'h0));
      cmdq[0].push_back(mk(1'b0, 1'b0, 32'd277, 32'h0));
      wait_idle();

      // Random traffic, disjoint address windows per master
      rand_gap = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         cmdq[0].push_back(rand_cmd(0));
         cmdq[1].push_back(rand_cmd(1));
      end
      wait_idle();
      rand_gap = 1'b0;

      // Reset during the access cycle of a word write
      @(negedge clk);
      cmdq[0].push_back(mk(1'b1, 1'b1, 32'd200, 32'h1357_9BDF));
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (m0_gnt) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail("rst_test_no_gnt");
      chk("rst_test_wr_on", 64'(mem_wr), 64'(1));
      #2 rst_n = 1'b0;
      #1 chk("rst_async_drop", 64'({mem_wr, mem_rd, m0_gnt}), 64'(0));
      repeat (3) @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | m0_rvalid | m1_rvalid;
      end
      chk("no_rvalid_after_rst", 64'(seen), 64'(0));

      // Priority back to m0 after reset
      base = gnt_log.size();
      @(negedge clk);
      cmdq[0].push_back(mk(1'b0, 1'b0, 32'd8, 32'h0));
      cmdq[1].push_back(mk(1'b0, 1'b0, 32'd300, 32'h0));
      wait_idle();
      chk("post_rst_count", 64'(gnt_log.size() - base), 64'(2));
      if (gnt_log.size() >= base + 2) chk("post_rst_first_m0", 64'(gnt_log[base].m), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      fail("watchdog");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-ported data_memory (byte/word `size`, `mem_rd`/`mem_wr` strobes, combinational `read_data`). It serialises accesses from two masters (m0 = load/store unit, m1 = secondary master, e.g. debug/DMA). It drives the memory control bus from registered state and returns read data with a completion pulse. It sits between the core's memory stage and data_memory.

Parameters:
ADDR_W, 32, address width of masters and memory bus
DATA_W, 32, data width of write/read paths

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mN_req (N=0,1)  input  1  master N access request; held with its command until mN_gnt
mN_wr  input  1  1 = write, 0 = read
mN_size  input  1  0 = byte, 1 = word (data_memory encoding)
mN_addr  input  ADDR_W  byte address
mN_wdata  input  DATA_W  write data
mN_gnt  output  1  one-cycle pulse: command accepted, on memory bus this cycle
mN_rvalid  output  1  one-cycle completion pulse, for reads and writes
mN_rdata  output  DATA_W  read data, valid while mN_rvalid=1
mN_err  output  1  access error, valid with mN_rvalid (see optional feature)
mem_address  output  ADDR_W  to data_memory address
mem_size  output  1  to data_memory size
mem_write_data  output  DATA_W  to data_memory write_data
mem_rd  output  1  to data_memory mem_rd
mem_wr  output  1  to data_memory mem_wr
mem_read_data  input  DATA_W  from data_memory read_data

Behaviour:
- Reset (rst_n=0, async): state=IDLE, prio=0, all outputs 0; mem_rd/mem_wr drop immediately, not at the next edge.
- States: IDLE, ACCESS, RESP. The state register and owner bit (`own`) drive all memory-bus outputs directly, with no combinational path from mN_* to mem_*.
- Arbitration (in IDLE or RESP): if exactly one req, select it. If both, select master `prio`. At the edge, latch the selected master's wr/size/addr/wdata into command registers, set `own`, go to ACCESS, and set prio = ~own_selected.
- ACCESS, exactly 1 cycle:
  - mem_address/mem_size/mem_write_data = latched command.
  - mem_wr=cmd_wr, mem_rd=~cmd_wr.
  - m[own]_gnt=1.
  - The memory commits the write at the end-of-cycle edge.
  - mem_read_data is captured into an internal rdata register at the same edge.
  - Next state is RESP.
- RESP, 1 cycle:
  - mem_rd=mem_wr=0.
  - m[own]_rvalid=1.
  - m[own]_rdata = captured data for reads, 0 for writes.
  - Arbitration is evaluated here: a pending req goes to ACCESS next, otherwise to IDLE.
- Latency: req sampled high in IDLE at edge E → gnt in cycle E..E+1 → rvalid in cycle E+1..E+2. Back-to-back throughput is one access per 2 cycles.
- A master sees gnt then rvalid on consecutive cycles. It must drop or change req in the cycle after gnt; a req still high in RESP is treated as a new request.
- The non-owner's gnt/rvalid/err stay 0. The non-owner's rdata holds 0.
- req deasserted before gnt: the request is withdrawn, no access.
- Byte reads: rdata is passed through unchanged; extension is the memory's responsibility.
- No simultaneous mem_rd and mem_wr, ever.
- Reset mid-ACCESS: strobes drop asynchronously, no rvalid is issued after reset release, and prio returns to 0.

Optional Feature:
ALIGN_CHECK_EN:
- Defined: in ACCESS, a word access (cmd_size=1) with cmd_addr[1:0]≠0 keeps mem_rd=mem_wr=0 (gnt still pulses). The following RESP asserts rvalid=1, err=1, rdata=0. Byte accesses are never flagged.
- Undefined: mN_err tied 0 and the address passes through unchanged. Misaligned word accesses go to memory as-is.

Test Plan:
- Reset: hold rst_n=0 while m0_req=1 → all outputs 0, no gnt. Release → gnt appears one cycle after the first sampling edge.
- m0 byte write addr=0 wdata=277 (0x115), then byte read addr=0 → write: gnt, then rvalid with rdata=0. Read: m0_rdata=0x00000015 with m0_rvalid=1 exactly 2 cycles after req sampled.
- m1 word write addr=276 wdata=0xDEADBEEF, then word read addr=276 → m1_rdata=0xDEADBEEF, m0_gnt/rvalid never asserted.
- Both req held high from reset release, 6 accesses → gnt order m0,m1,m0,m1,m0,m1, one gnt every 2 cycles, mem_rd&mem_wr never both 1.
- Assert rst_n=0 mid-cycle during ACCESS of a word write → mem_wr falls before next clk edge, no rvalid after release, next contention grants m0.
- With ALIGN_CHECK_EN, m0 word read addr=277 → mem_rd stays 0, m0_rvalid=1, m0_err=1, m0_rdata=0. A byte read at addr=277 → err=0. Without the macro, err stays 0.
